fp_aligner: RTL
===============

FP_ALIGNER -- requirements
Module: fp_aligner

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair is presented.
REQ-005 in_ready  output  1  block can accept a pair.
REQ-006 opA, opB  input  32 each  IEEE-754 single-precision operands.
REQ-007 out_valid  output  1  aligned result is presented.
REQ-008 out_ready  input  1  downstream accepts the result.
REQ-009 alignedMantissaA, alignedMantissaB  output  24 each  larger-magnitude operand significand, and smaller operand significand after right shift (both include the implicit bit).
REQ-010 exponentOut  output  8  effective exponent of the larger operand.
REQ-011 signA, signB  output  1 each  signs after swap.
REQ-012 guardBit, roundBit, stickyBit  output  1 each  bits shifted out of the smaller significand.
REQ-013 swapped  output  1  operands were exchanged.
REQ-014 special  output  1  either operand has exponent 0xFF.

Function
REQ-015 Unpack rule: exponent 0 SHALL give implicit bit 0 and effective exponent 1; otherwise implicit bit 1 and the field exponent.
REQ-016 FSM states SHALL be IDLE, CMP, SHIFT and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; a pair SHALL be accepted on the edge where in_valid and in_ready are both 1, and the FSM then SHALL go to CMP.
REQ-018 CMP swap: swap SHALL occur when (expB, mantB) > (expA, mantA), compared exponent first, then significand; swapped SHALL be set accordingly.
REQ-019 CMP load: CMP SHALL load the shift counter with min(expA-expB, 26) and clear G/R/S.
REQ-020 CMP exit: next state SHALL be DONE if the count is 0 or special=1 (no shift); otherwise SHIFT.
REQ-021 SHIFT step, one per cycle: mantB >>= 1, guard <= old mantB[0], round <= old guard, sticky <= sticky | old round, counter decrements.
REQ-022 SHIFT exit: SHIFT SHALL exit to DONE on the cycle the counter goes from 1 to 0.
REQ-023 Latency: with acceptance at edge T, out_valid SHALL rise after edge T+2+k, where k = min(diff, 26); k=0 for special.
REQ-024 DONE: out_valid=1 and all outputs SHALL be held stable until out_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-025 Back-to-back: a new pair SHALL be accepted at the earliest one cycle after the handshake.
REQ-026 Out-of-state signals: out_ready outside DONE and in_valid outside IDLE SHALL be ignored.
REQ-027 Saturation: the 26-shift cap SHALL produce results identical to exact shifting for any larger difference.

Reset
REQ-028 On reset the FSM SHALL go to IDLE, with out_valid=0, all data outputs 0 and the counter 0.
REQ-029 in_ready SHALL be 1 in the first cycle after reset.
REQ-030 Reset in any state, including mid-SHIFT or DONE with out_valid=1, SHALL abandon the operation with no output handshake.

Structure
REQ-031 State enum, the shift-cap constant (26) and the exponent-all-ones constant SHALL live in the shared fp package.
REQ-032 Field extraction (sign, effective exponent, significand, special detect) SHALL be a combinational sub-module fp_unpack, instantiated once per operand.

Verification
REQ-033 Equal exponents: 0x3F800000 + 0x3F800000 -> out_valid at T+2; both mantissas 0x800000; exponentOut 0x7F; G/R/S = 0/0/0; swapped 0.
REQ-034 Difference 1: 0x3F800000 + 0x3F400000 -> mantB 0x600000; exponentOut 0x7F; G/R/S = 0/0/0; out_valid at T+3.
REQ-035 Swap: opA 0x3F000000, opB 0x40000000 -> swapped 1; exponentOut 0x80; mantA 0x800000; mantB 0x200000; out_valid at T+4.
REQ-036 Difference 24: 0x3F800000 + 0x33800000 -> mantB 0; G/R/S = 1/0/0; out_valid at T+26.
REQ-037 Saturated: 0x7F000000 + 0x3F800001 -> mantB 0; G/R/S = 0/0/1; out_valid at T+28.
REQ-038 Handshake and reset:
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable.
- Assert reset mid-SHIFT -> next cycle in IDLE, out_valid 0, in_ready 1.

Source files
------------

// File: rtl/fp_aligner_pkg.sv
// Shared types and constants for the single-precision operand aligner.
// Holds the FSM state encoding, field layout and shift-cap helper.
package fp_aligner_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned EXP_W     = 8;
  localparam int unsigned FRAC_W    = 23;
  localparam int unsigned MANT_W    = FRAC_W + 1;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned SHIFT_CAP = 26;

  localparam logic [EXP_W-1:0] EXP_ALL_ONES = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    SHIFT,
    DONE
  } alignState_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [MANT_W-1:0] mantissa;
    logic              special;
  } fpFields_t;

  // Beyond 26 positions every bit of the significand has already reached sticky.
  function automatic logic [CNT_W-1:0] capShift(input logic [EXP_W-1:0] diff);
    return (diff > EXP_W'(SHIFT_CAP)) ? CNT_W'(SHIFT_CAP) : diff[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational field extraction for one IEEE-754 single-precision operand.
// Denormals take effective exponent 1 with a zero implicit bit.
module fp_unpack
  import fp_aligner_pkg::*;
(
  input  logic [WORD_W-1:0] op,
  output fpFields_t         fields_c
);

  logic [EXP_W-1:0] expField;

  assign expField = op[WORD_W-2 -: EXP_W];

  always_comb begin
    fields_c.sign    = op[WORD_W-1];
    fields_c.special = (expField == EXP_ALL_ONES);
    if (expField == '0) begin
      fields_c.exponent = EXP_W'(1);
      fields_c.mantissa = {1'b0, op[FRAC_W-1:0]};
    end else begin
      fields_c.exponent = expField;
      fields_c.mantissa = {1'b1, op[FRAC_W-1:0]};
    end
  end

endmodule

// File: rtl/fp_aligner.sv
// Aligns two single-precision operands for addition: orders them by magnitude and
// right-shifts the smaller significand one bit per cycle, collecting G/R/S.
module fp_aligner
  import fp_aligner_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] opA,
  input  logic [WORD_W-1:0] opB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] alignedMantissaA,
  output logic [MANT_W-1:0] alignedMantissaB,
  output logic [EXP_W-1:0]  exponentOut,
  output logic              signA,
  output logic              signB,
  output logic              guardBit,
  output logic              roundBit,
  output logic              stickyBit,
  output logic              swapped,
  output logic              special
);

  alignState_e       state;
  logic [WORD_W-1:0] opAReg;
  logic [WORD_W-1:0] opBReg;
  logic [CNT_W-1:0]  shiftCount;

  fpFields_t fieldA;
  fpFields_t fieldB;
  fpFields_t bigField;
  fpFields_t smallField;
  logic      bLarger;
  logic      anySpecial;
  logic [EXP_W-1:0] expDiff;
  logic [CNT_W-1:0] shiftLoad;

  fp_unpack unpackA (.op(opAReg), .fields_c(fieldA));
  fp_unpack unpackB (.op(opBReg), .fields_c(fieldB));

  // Magnitude ordering: exponent first, significand breaks ties.
  always_comb begin
    bLarger    = {fieldB.exponent, fieldB.mantissa} > {fieldA.exponent, fieldA.mantissa};
    bigField   = bLarger ? fieldB : fieldA;
    smallField = bLarger ? fieldA : fieldB;
    anySpecial = fieldA.special | fieldB.special;
    expDiff    = bigField.exponent - smallField.exponent;
    shiftLoad  = capShift(expDiff);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      in_ready         <= 1'b1;
      out_valid        <= 1'b0;
      opAReg           <= '0;
      opBReg           <= '0;
      shiftCount       <= '0;
      alignedMantissaA <= '0;
      alignedMantissaB <= '0;
      exponentOut      <= '0;
      signA            <= 1'b0;
      signB            <= 1'b0;
      guardBit         <= 1'b0;
      roundBit         <= 1'b0;
      stickyBit        <= 1'b0;
      swapped          <= 1'b0;
      special          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opAReg   <= opA;
            opBReg   <= opB;
            in_ready <= 1'b0;
            state    <= CMP;
          end
        end

        CMP: begin
          alignedMantissaA <= bigField.mantissa;
          alignedMantissaB <= smallField.mantissa;
          exponentOut      <= bigField.exponent;
          signA            <= bigField.sign;
          signB            <= smallField.sign;
          swapped          <= bLarger;
          special          <= anySpecial;
          guardBit         <= 1'b0;
          roundBit         <= 1'b0;
          stickyBit        <= 1'b0;
          if (anySpecial || shiftLoad == '0) begin
            shiftCount <= '0;
            state      <= DONE;
          end else begin
            shiftCount <= shiftLoad;
            state      <= SHIFT;
          end
        end

        SHIFT: begin
          alignedMantissaB <= alignedMantissaB >> 1;
          guardBit         <= alignedMantissaB[0];
          roundBit         <= guardBit;
          stickyBit        <= stickyBit | roundBit;
          shiftCount       <= shiftCount - CNT_W'(1);
          if (shiftCount == CNT_W'(1)) begin
            state <= DONE;
          end
        end

        DONE: begin
          // First DONE cycle raises out_valid; the handshake needs it already high.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
